// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer
//   Run controller between the top-level bench and the MIPS CPU. Issues an
//   active-low reset pulse to the CPU, then enables execution. It counts the
//   RUN cycles and stops either when the PC has stayed unchanged for
//   HALT_STABLE consecutive cycles (halt) or when MAX_CYCLES is reached
//   (timeout). If halt and timeout land in the same cycle, halt wins.
//
//   Ports:
//     clock        system clock, rising edge
//     reset        synchronous active-high reset
//     start        one-cycle request to begin a reset+run sequence
//     pc           CPU program counter, sampled every RUN cycle
//     cpu_reset_n  active-low reset to the CPU (low only in RESET)
//     cpu_run      CPU clock enable (high only in RUN)
//     busy         high in RESET and RUN
//     done         high in DONE
//     timeout      valid while done: 1 = MAX_CYCLES reached, 0 = halt
//     cycle_count  number of RUN cycles executed
//     final_pc     PC sampled in the last RUN cycle
//
//   Optional build macro RUN_TRACE_EN adds:
//     trace_valid  one-cycle pulse after a RUN cycle (k>1) whose PC changed
//     trace_pc     the new PC for that pulse
//     change_count number of PC changes in the current run
//
//   state  | meaning
//   IDLE   | waiting for start, CPU held out of reset but not running
//   RESET  | cpu_reset_n low for RST_CYCLES cycles
//   RUN    | CPU enabled, halt/timeout monitored
//   DONE   | run finished, results held until the next start
module cpu_run_sequencer #(
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int RST_CYCLES  = 1,
  parameter int MAX_CYCLES  = 6,
  parameter int HALT_STABLE = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_reset_n,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  final_pc
`ifdef RUN_TRACE_EN
  ,
  output logic                 trace_valid,
  output logic [PC_WIDTH-1:0]  trace_pc,
  output logic [CNT_WIDTH-1:0] change_count
`endif
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0]        rst_cnt;
  logic [PC_WIDTH-1:0]  prev_pc;
  logic [CNT_WIDTH-1:0] stable_cnt;

  logic [CNT_WIDTH-1:0] run_k;
  logic [CNT_WIDTH-1:0] stable_nxt;
  logic                 first_run;
  logic                 pc_same;
  logic                 halt;
  logic                 tmo;
  logic                 rst_last;
  logic                 launch;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // cycle_count is cleared on launch, so it holds k-1 during RUN cycle k
    run_k       = cycle_count + CNT_WIDTH'(1);
    first_run   = (cycle_count == '0);
    pc_same     = (pc == prev_pc);
    stable_nxt  = (!first_run && pc_same) ? stable_cnt + CNT_WIDTH'(1) : '0;
    halt        = (stable_nxt == CNT_WIDTH'(HALT_STABLE));
    tmo         = (run_k == CNT_WIDTH'(MAX_CYCLES));
    rst_last    = (rst_cnt == '0);
    launch      = 1'b0;
    state_nxt   = state;
    cpu_reset_n = 1'b1;
    cpu_run     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = S_RESET;
        end
      end
      S_RESET: begin
        cpu_reset_n = 1'b0;
        busy        = 1'b1;
        if (rst_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_run = 1'b1;
        busy    = 1'b1;
        if (halt || tmo) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          launch    = 1'b1;
          state_nxt = S_RESET;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
      final_pc    <= '0;
      timeout     <= 1'b0;
      prev_pc     <= '0;
      stable_cnt  <= '0;
      rst_cnt     <= '0;
    end else if (launch) begin
      cycle_count <= '0;
      final_pc    <= '0;
      timeout     <= 1'b0;
      stable_cnt  <= '0;
      // down-counter: RESET ends when it reaches zero
      rst_cnt     <= RW'(RST_CYCLES - 1);
    end else if (state == S_RESET) begin
      if (!rst_last) rst_cnt <= rst_cnt - RW'(1);
    end else if (state == S_RUN) begin
      cycle_count <= run_k;
      final_pc    <= pc;
      prev_pc     <= pc;
      stable_cnt  <= stable_nxt;
      if (halt)     timeout <= 1'b0;
      else if (tmo) timeout <= 1'b1;
    end
  end

`ifdef RUN_TRACE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      trace_valid  <= 1'b0;
      trace_pc     <= '0;
      change_count <= '0;
    end else begin
      trace_valid <= 1'b0;
      if (launch) begin
        change_count <= '0;
      end else if (state == S_RUN && !first_run && !pc_same) begin
        trace_valid  <= 1'b1;
        trace_pc     <= pc;
        change_count <= change_count + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: two instances (defaults, and RST_CYCLES=3 /
// MAX_CYCLES=5) driven with directed and random PC sequences; expected run
// length and termination cause come from a sequence-level model.
module tb_cpu_run_sequencer;

  localparam int HS = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, start_a, reset_b, start_b;
  logic [31:0] pc_a, pc_b;
  logic        crn_a, run_a, busy_a, done_a, to_a;
  logic        crn_b, run_b, busy_b, done_b, to_b;
  logic [15:0] cc_a, cc_b;
  logic [31:0] fpc_a, fpc_b;
`ifdef RUN_TRACE_EN
  logic        tv_a, tv_b;
  logic [31:0] tpc_a, tpc_b;
  logic [15:0] chg_a, chg_b;
`endif

  cpu_run_sequencer dut_a (
    .clock(clock), .reset(reset_a), .start(start_a), .pc(pc_a),
    .cpu_reset_n(crn_a), .cpu_run(run_a), .busy(busy_a), .done(done_a),
    .timeout(to_a), .cycle_count(cc_a), .final_pc(fpc_a)
`ifdef RUN_TRACE_EN
    , .trace_valid(tv_a), .trace_pc(tpc_a), .change_count(chg_a)
`endif
  );

  cpu_run_sequencer #(.RST_CYCLES(3), .MAX_CYCLES(5)) dut_b (
    .clock(clock), .reset(reset_b), .start(start_b), .pc(pc_b),
    .cpu_reset_n(crn_b), .cpu_run(run_b), .busy(busy_b), .done(done_b),
    .timeout(to_b), .cycle_count(cc_b), .final_pc(fpc_b)
`ifdef RUN_TRACE_EN
    , .trace_valid(tv_b), .trace_pc(tpc_b), .change_count(chg_b)
`endif
  );

  int total  = 0;
  int passed = 0;
  logic [31:0] pcs [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic o_crn(input int s);  return s != 0 ? crn_b  : crn_a;  endfunction
  function automatic logic o_run(input int s);  return s != 0 ? run_b  : run_a;  endfunction
  function automatic logic o_busy(input int s); return s != 0 ? busy_b : busy_a; endfunction
  function automatic logic o_done(input int s); return s != 0 ? done_b : done_a; endfunction
  function automatic logic o_to(input int s);   return s != 0 ? to_b   : to_a;   endfunction
  function automatic logic [15:0] o_cc(input int s);  return s != 0 ? cc_b  : cc_a;  endfunction
  function automatic logic [31:0] o_fpc(input int s); return s != 0 ? fpc_b : fpc_a; endfunction
`ifdef RUN_TRACE_EN
  function automatic logic o_tv(input int s); return s != 0 ? tv_b : tv_a; endfunction
  function automatic logic [31:0] o_tpc(input int s); return s != 0 ? tpc_b : tpc_a; endfunction
  function automatic logic [15:0] o_chg(input int s); return s != 0 ? chg_b : chg_a; endfunction
`endif

  task automatic set_start(input int s, input logic v);
    if (s != 0) start_b = v; else start_a = v;
  endtask
  task automatic set_reset(input int s, input logic v);
    if (s != 0) reset_b = v; else reset_a = v;
  endtask
  task automatic set_pc(input int s, input logic [31:0] v);
    if (s != 0) pc_b = v; else pc_a = v;
  endtask

  // Run ends at the first k where the last HS+1 PCs are identical (halt),
  // otherwise at k == mc (timeout).
  function automatic int end_of_run(input int mc, output bit to);
    for (int k = 1; k <= mc; k++) begin
      bit same;
      same = (k > HS);
      if (k > HS)
        for (int j = 1; j <= HS; j++)
          if (pcs[k-1] != pcs[k-1-j]) same = 1'b0;
      if (same) begin
        to = 1'b0;
        return k;
      end
    end
    to = 1'b1;
    return mc;
  endfunction

  task automatic check_idle(input int s, input string tag);
    chk({tag, ".crn"},  32'(o_crn(s)),  32'd1);
    chk({tag, ".run"},  32'(o_run(s)),  32'd0);
    chk({tag, ".busy"}, 32'(o_busy(s)), 32'd0);
    chk({tag, ".done"}, 32'(o_done(s)), 32'd0);
    chk({tag, ".to"},   32'(o_to(s)),   32'd0);
    chk({tag, ".cc"},   32'(o_cc(s)),   32'd0);
    chk({tag, ".fpc"},  o_fpc(s),       32'd0);
  endtask

  // Called at a negedge; pcs[] holds the PC per RUN cycle.
  task automatic run_case(input int s, input string tag);
    int rc, mc, ek, nchg;
    bit to;
    rc = (s != 0) ? 3 : 1;
    mc = (s != 0) ? 5 : 6;
    ek = end_of_run(mc, to);
    nchg = 0;
    set_start(s, 1'b1);
    @(negedge clock);
    for (int i = 0; i < rc; i++) begin
      chk({tag, ".rst_crn"},  32'(o_crn(s)),  32'd0);
      chk({tag, ".rst_run"},  32'(o_run(s)),  32'd0);
      chk({tag, ".rst_busy"}, 32'(o_busy(s)), 32'd1);
      chk({tag, ".rst_done"}, 32'(o_done(s)), 32'd0);
      if (i == 0) chk({tag, ".rst_cc"}, 32'(o_cc(s)), 32'd0);
      set_start(s, (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      @(negedge clock);
    end
    for (int k = 1; k <= ek; k++) begin
      chk({tag, ".run_run"},  32'(o_run(s)),  32'd1);
      chk({tag, ".run_crn"},  32'(o_crn(s)),  32'd1);
      chk({tag, ".run_done"}, 32'(o_done(s)), 32'd0);
      chk({tag, ".run_cc"},   32'(o_cc(s)),   32'(k - 1));
`ifdef RUN_TRACE_EN
      if (k == 1) chk({tag, ".tv_first"}, 32'(o_tv(s)), 32'd0);
      else begin
        bit ch;
        ch = (k > 2) && (pcs[k-2] != pcs[k-3]);
        chk({tag, ".tv"}, 32'(o_tv(s)), 32'(ch));
        if (ch) chk({tag, ".tpc"}, o_tpc(s), pcs[k-2]);
      end
      if (k > 1 && pcs[k-1] != pcs[k-2]) nchg++;
`endif
      set_pc(s, pcs[k-1]);
      set_start(s, 1'($urandom_range(0, 1)));
      @(negedge clock);
    end
    set_start(s, 1'b0);
    set_pc(s, $urandom);
    chk({tag, ".done"},     32'(o_done(s)), 32'd1);
    chk({tag, ".done_run"}, 32'(o_run(s)),  32'd0);
    chk({tag, ".done_busy"},32'(o_busy(s)), 32'd0);
    chk({tag, ".done_crn"}, 32'(o_crn(s)),  32'd1);
    chk({tag, ".timeout"},  32'(o_to(s)),   32'(to));
    chk({tag, ".cc"},       32'(o_cc(s)),   32'(ek));
    chk({tag, ".fpc"},      o_fpc(s),       pcs[ek-1]);
`ifdef RUN_TRACE_EN
    begin
      bit ch;
      ch = (ek > 1) && (pcs[ek-1] != pcs[ek-2]);
      chk({tag, ".tv_last"}, 32'(o_tv(s)), 32'(ch));
      if (ch) chk({tag, ".tpc_last"}, o_tpc(s), pcs[ek-1]);
      chk({tag, ".chg"}, 32'(o_chg(s)), 32'(nchg));
    end
`endif
    @(negedge clock);
    chk({tag, ".hold_done"}, 32'(o_done(s)), 32'd1);
    chk({tag, ".hold_cc"},   32'(o_cc(s)),   32'(ek));
    chk({tag, ".hold_fpc"},  o_fpc(s),       pcs[ek-1]);
  endtask

  task automatic reset_mid_run(input int s, input string tag);
    int rc;
    rc = (s != 0) ? 3 : 1;
    set_start(s, 1'b1);
    @(negedge clock);
    set_start(s, 1'b0);
    repeat (rc) @(negedge clock);
    for (int k = 1; k <= 2; k++) begin
      set_pc(s, 32'(4 * k));
      @(negedge clock);
    end
    chk({tag, ".pre_run"}, 32'(o_run(s)), 32'd1);
    chk({tag, ".pre_cc"},  32'(o_cc(s)),  32'd2);
    set_pc(s, 32'd12);
    set_reset(s, 1'b1);
    @(negedge clock);
    set_reset(s, 1'b0);
    check_idle(s, tag);
    @(negedge clock);
    chk({tag, ".idle_busy"}, 32'(o_busy(s)), 32'd0);
    chk({tag, ".idle_crn"},  32'(o_crn(s)),  32'd1);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    pc_a = '0; pc_b = '0;
    repeat (3) @(negedge clock);
    reset_a = 1'b0; reset_b = 1'b0;
    check_idle(0, "por_a");
    check_idle(1, "por_b");
    @(negedge clock);

    pcs[0] = 0; pcs[1] = 4; pcs[2] = 8; pcs[3] = 12; pcs[4] = 16; pcs[5] = 20;
    run_case(0, "timeout");

    pcs[0] = 0; pcs[1] = 4; pcs[2] = 8; pcs[3] = 8; pcs[4] = 8;
    run_case(0, "halt");
    run_case(1, "coincident");

    pcs[0] = 0; pcs[1] = 4; pcs[2] = 4; pcs[3] = 8; pcs[4] = 8; pcs[5] = 8;
    run_case(1, "restart_b");
    run_case(0, "trace_seq");

    reset_mid_run(0, "midrst_a");
    reset_mid_run(1, "midrst_b");
    pcs[0] = 0; pcs[1] = 4; pcs[2] = 8; pcs[3] = 12; pcs[4] = 16; pcs[5] = 20;
    run_case(0, "after_rst");

    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 16; i++) pcs[i] = 32'(4 * $urandom_range(0, 2));
      run_case(it % 2, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
Synthesizable run controller that sits between the top-level bench and the MIPS CPU.
- Generates the CPU's active-low reset pulse and gates CPU execution.
- Counts executed cycles and declares completion on halt (PC stable) or on timeout.
- Replaces fixed-delay reset/run sequencing with parametrised depth, timeout and halt detection.

Parameters:
- PC_WIDTH, 32, width of the monitored program counter.
- CNT_WIDTH, 16, width of the cycle counter.
- RST_CYCLES, 1, number of cycles cpu_reset_n is held low (legal range ≥1).
- MAX_CYCLES, 6, run-cycle timeout limit (legal range ≥1, < 2^CNT_WIDTH).
- HALT_STABLE, 2, consecutive unchanged-PC cycles that declare a halt (legal range ≥1).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a reset+run sequence.
- pc  input  PC_WIDTH  CPU program counter, sampled each RUN cycle.
- cpu_reset_n  output  1  active-low reset driven to the CPU.
- cpu_run  output  1  CPU clock-enable; high only in RUN.
- busy  output  1  high in RESET and RUN.
- done  output  1  level; high in DONE.
- timeout  output  1  valid while done; 1 = ended by MAX_CYCLES, 0 = ended by halt.
- cycle_count  output  CNT_WIDTH  number of RUN cycles executed.
- final_pc  output  PC_WIDTH  PC sampled in the last RUN cycle.

Behaviour:
- Reset (reset=1 at an edge) sets:
  - state IDLE.
  - cpu_reset_n=1, cpu_run=0, busy=0, done=0, timeout=0.
  - cycle_count=0, final_pc=0.
  - Internal prev_pc=0, stable_cnt=0, rst_cnt=0.
- Reset has priority over every other event, including mid-RESET and mid-RUN. The next cycle is IDLE with cpu_reset_n=1.
- States:
  - IDLE: outputs idle. start=1 → RESET; clears cycle_count, final_pc, timeout, stable_cnt.
  - RESET: cpu_reset_n=0, busy=1, cpu_run=0 for exactly RST_CYCLES cycles, then → RUN. start is ignored.
  - RUN: cpu_run=1, busy=1, cpu_reset_n=1. start is ignored.
  - DONE: done=1; outputs hold. start=1 → RESET with the same clears as IDLE, so done drops in the next cycle.
- RUN cycle k (k=1,2,…), evaluated at the closing edge:
  - cycle_count←k; final_pc←pc; prev_pc←pc.
  - k=1: stable_cnt←0 (no comparison).
  - k>1: stable_cnt←(pc==prev_pc) ? stable_cnt+1 : 0.
  - halt = (new stable_cnt == HALT_STABLE) → DONE, timeout←0.
  - Otherwise, if k==MAX_CYCLES → DONE, timeout←1.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- cycle_count never exceeds MAX_CYCLES. No wrap-around is possible within the legal parameter range.
- Latency:
  - start edge → cpu_reset_n low in the next cycle.
  - First RUN cycle begins RST_CYCLES cycles later.
  - done rises the cycle after the terminating RUN cycle.

Optional Feature:
RUN_TRACE_EN
- Defined: adds three outputs.
  - trace_valid (1): registered; high for one cycle after any RUN cycle k>1 where pc≠prev_pc.
  - trace_pc (PC_WIDTH): the new PC for that trace_valid pulse.
  - change_count (CNT_WIDTH): number of PC changes. Cleared on reset and on entry to RESET; holds in DONE.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Timeout: defaults; start pulse; pc=0,4,8,12,16,20 → cpu_reset_n low exactly 1 cycle; cpu_run high 6 cycles; then done=1, timeout=1, cycle_count=6, final_pc=20.
2. Halt: defaults; pc=0,4,8,8,8 → done after 5th RUN cycle; timeout=0, cycle_count=5, final_pc=8; cpu_run=0 from then.
3. Coincident halt and timeout: MAX_CYCLES=5; same pc sequence as test 2 → done with timeout=0, cycle_count=5.
4. Reset mid-run: reset=1 during RUN cycle 3 → next cycle: IDLE, cpu_reset_n=1, cpu_run=0, busy=0, cycle_count=0; later start runs normally.
5. Restart from DONE, with RST_CYCLES=3: after test 2, start pulse → done=0 and cycle_count=0 next cycle; cpu_reset_n low 3 cycles; start asserted during RUN has no effect.
6. RUN_TRACE_EN: pc=0,4,4,8,8,8 → trace_valid pulses twice (trace_pc=4 then 8); change_count=2 in DONE.
